// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM state encodings for the logic operation stage.
package logic_op_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational logic primitives (AND, OR, XOR, 8-bit NOT) and result select.
module logic_op_core
  import logic_op_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic [7:0] o_result
);

  logic [3:0] w_and;
  logic [3:0] w_or;
  logic [3:0] w_xor;
  logic [7:0] w_not;

  assign w_and = i_x & i_y;
  assign w_or  = i_x | i_y;
  assign w_xor = i_x ^ i_y;
  // NOT works on the full byte with y in the upper nibble.
  assign w_not = ~{i_y, i_x};

  // Select the primitive output; 4-bit results are zero-extended.
  always_comb begin
    o_result = 8'h00;
    case (i_op)
      OP_AND:  o_result = {4'h0, w_and};
      OP_OR:   o_result = {4'h0, w_or};
      OP_XOR:  o_result = {4'h0, w_xor};
      OP_NOT:  o_result = w_not;
      default: o_result = 8'h00;
    endcase
  end

endmodule

// File: rtl/logic_op_stage.sv
// Registered issue/retire stage: capture on handshake, compute, hold until consumed.
module logic_op_stage
  import logic_op_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [7:0]       r_result;
  logic             r_zero;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       w_core_result;
  logic             w_accept;
  logic             w_retire;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_retire = (r_state == S_HOLD) && out_ready;

  logic_op_core u_core (
    .i_op     (r_op),
    .i_x      (r_x),
    .i_y      (r_y),
    .o_result (w_core_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: one cycle each in IDLE and EXEC, HOLD until consumed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_HOLD;
      S_HOLD:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture on accepted request only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= OP_AND;
      r_x  <= 4'h0;
      r_y  <= 4'h0;
    end else if (w_accept) begin
      r_op <= in_op;
      r_x  <= in_x;
      r_y  <= in_y;
    end
  end

  // Result and zero flag are loaded in EXEC and held through HOLD and beyond.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 8'h00;
      r_zero   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_result <= w_core_result;
      r_zero   <= (w_core_result == 8'h00);
    end
  end

  // Retired-operation counter; wraps silently.
  always_ff @(posedge clk) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + CNT_W'(1);
  end

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign op_count   = r_count;

endmodule
